dma_frame_event_gen: RTL
========================

DMA_FRAME_EVENT_GEN -- requirements
Module: dma_frame_event_gen

Interface
REQ-001 Parameter: BCNT_WIDTH, 16, width of the per-frame burst count.
REQ-002 Parameter: PULSE_WIDTH, 4, event pulse high time in clocks (legal 2..15).
REQ-003 Port: sys_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_i  in  1  reset; one clock, asynchronous and active-high.
REQ-005 Port: dma_en_i  in  1  channel enable; level.
REQ-006 Port: frame_start_i  in  1  one-cycle start-of-frame strobe.
REQ-007 Port: bursts_per_frame_i  in  BCNT_WIDTH  write bursts expected per frame; sampled on accepted frame_start_i.
REQ-008 Port: bvalid_i  in  1  AXI write response valid (monitored).
REQ-009 Port: bready_i  in  1  AXI write response ready (monitored).
REQ-010 Port: bresp_i  in  2  AXI write response code.
REQ-011 Port: event_o  out  3  stretched events to the interrupt controller: [0] frame done, [1] frame overrun, [2] write response error.
REQ-012 Port: frame_cnt_o  out  16  completed-frame counter.
REQ-013 Port: busy_o  out  1  high while state is ACTIVE.

Function
REQ-014 States SHALL be IDLE and ACTIVE; busy_o = (state==ACTIVE), registered.
REQ-015 A response handshake SHALL be bvalid_i && bready_i in the same cycle; only handshakes in ACTIVE are counted.
REQ-016 frame_start_i SHALL be accepted only when dma_en_i=1; when dma_en_i=0 it is ignored.
REQ-017 Accepted start, bursts_per_frame_i!=0: remaining <= bursts_per_frame_i, state -> ACTIVE next cycle.
REQ-018 Accepted start, bursts_per_frame_i==0: stay IDLE, request frame-done, increment frame_cnt_o.
REQ-019 ACTIVE handshake: remaining decrements by 1; when remaining==1, frame-done request, frame_cnt_o +1, state -> IDLE.
REQ-020 Accepted start while ACTIVE with remaining>1 or no final handshake that cycle: overrun request, old frame abandoned (no done, no count), remaining reloaded, stay ACTIVE.
REQ-021 Accepted start in the same cycle as the final handshake: done request for old frame, no overrun, new frame loaded per REQ-017/018.
REQ-022 ACTIVE handshake with bresp_i!=2'b00: error request; handshake still counted.
REQ-023 dma_en_i=0 in ACTIVE: state -> IDLE next cycle, no done, no count; handshake that cycle ignored.
REQ-024 frame_cnt_o SHALL wrap 16'hFFFF -> 16'h0000.
REQ-025 Each event bit SHALL have an independent stretcher: request at cycle N -> bit high N+1 through N+PULSE_WIDTH, then low >= 2 cycles.
REQ-026 A request arriving while its bit is high or in its 2-cycle low gap SHALL set a 1-deep pending flag; pending issues a new pulse immediately after the gap; further requests while pending is set are dropped.
REQ-027 event_o SHALL be driven directly from flops (glitch-free; downstream synchronizes).
REQ-028 Requests on multiple bits in one cycle SHALL pulse all those bits in parallel.

Reset
REQ-029 rst_i=1 SHALL immediately force: state IDLE, remaining 0, busy_o 0, event_o 3'b000, pending flags 0, stretch counters 0, frame_cnt_o 0.
REQ-030 Reset asserted mid-frame or mid-pulse SHALL discard the frame and the pulse; no event after release until a new request.
REQ-031 First frame_start_i honoured on the first rising edge with rst_i=0.

Verification
REQ-032 Normal frame: dma_en=1, start with bursts=3, 3 handshakes bresp=0 -> busy 1 then 0, event_o[0] high 4 cycles starting the cycle after 3rd handshake, frame_cnt_o=1.
REQ-033 Overrun: bursts=4, 2 handshakes, new start with bursts=2 -> event_o[1] pulse, frame_cnt_o unchanged, 2 more handshakes -> event_o[0] pulse, frame_cnt_o=1.
REQ-034 Coincident: start on same cycle as final handshake -> event_o[0] only, busy_o stays 1, frame_cnt_o +1.
REQ-035 Back-to-back zero-burst starts on consecutive cycles -> two separate event_o[0] pulses separated by exactly 2 low cycles, frame_cnt_o=2; third start during second pulse -> third pulse follows.
REQ-036 Error and abort: bursts=2, handshake bresp=2'b10 -> event_o[2] pulse; then dma_en=0 -> IDLE, no done; later handshakes ignored.
REQ-037 Reset mid-pulse: assert rst_i during event_o[0] high -> event_o=0 same cycle, frame_cnt_o=0, no pulse after release; counter wrap from 16'hFFFF to 0 checked via 65536 zero-burst frames.

Source files
------------

// File: rtl/dma_frame_event_gen.sv
// Per-channel DMA frame tracker: counts AXI write responses against a per-frame
// burst budget and raises stretched done / overrun / error events.
module dma_frame_event_gen #(
    parameter int BCNT_WIDTH  = 16,
    parameter int PULSE_WIDTH = 4
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_i,
    input  logic                  dma_en_i,
    input  logic                  frame_start_i,
    input  logic [BCNT_WIDTH-1:0] bursts_per_frame_i,
    input  logic                  bvalid_i,
    input  logic                  bready_i,
    input  logic [1:0]            bresp_i,
    output logic [2:0]            event_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  busy_o
);

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_ACTIVE = 1'b1;

    // Stretch window = PULSE_WIDTH high cycles followed by a 2-cycle low gap.
    localparam logic [4:0] STRETCH_LOAD = 5'(PULSE_WIDTH + 1);

    logic                  state_reg, state_next;
    logic [BCNT_WIDTH-1:0] remaining_reg, remaining_next;
    logic [15:0]           frame_cnt_reg, frame_cnt_next;
    logic [2:0]            event_req;
    logic [1:0]            done_inc;

    logic handshake;
    logic start_accepted;
    logic zero_frame;
    logic final_handshake;

    assign handshake       = bvalid_i && bready_i;
    assign start_accepted  = frame_start_i && dma_en_i;
    assign zero_frame      = (bursts_per_frame_i == '0);
    assign final_handshake = handshake && (remaining_reg == BCNT_WIDTH'(1));

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        event_req      = 3'b000;
        done_inc       = 2'd0;

        case (state_reg)
            STATE_IDLE: begin
                if (start_accepted) begin
                    if (zero_frame) begin
                        event_req[0] = 1'b1;
                        done_inc     = 2'd1;
                    end else begin
                        remaining_next = bursts_per_frame_i;
                        state_next     = STATE_ACTIVE;
                    end
                end
            end
            default: begin
                if (!dma_en_i) begin
                    state_next     = STATE_IDLE;
                    remaining_next = '0;
                end else begin
                    if (handshake && (bresp_i != 2'b00)) begin
                        event_req[2] = 1'b1;
                    end
                    if (handshake) begin
                        remaining_next = remaining_reg - BCNT_WIDTH'(1);
                    end
                    if (final_handshake) begin
                        event_req[0] = 1'b1;
                        done_inc     = 2'd1;
                        state_next   = STATE_IDLE;
                    end
                    // A new start abandons the old frame unless it just completed.
                    if (start_accepted) begin
                        if (!final_handshake) begin
                            event_req[1] = 1'b1;
                        end
                        if (zero_frame) begin
                            event_req[0]   = 1'b1;
                            done_inc       = done_inc + 2'd1;
                            remaining_next = '0;
                            state_next     = STATE_IDLE;
                        end else begin
                            remaining_next = bursts_per_frame_i;
                            state_next     = STATE_ACTIVE;
                        end
                    end
                end
            end
        endcase

        frame_cnt_next = frame_cnt_reg + 16'(done_inc);
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= STATE_IDLE;
            remaining_reg <= '0;
            frame_cnt_reg <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign busy_o      = (state_reg == STATE_ACTIVE);
    assign frame_cnt_o = frame_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stretch
            logic [4:0] tmr_reg, tmr_next;
            logic       pend_reg, pend_next;
            logic       evt_reg;

            // tmr_reg == 0 means the window (high time plus gap) has fully elapsed.
            always_comb begin
                tmr_next  = tmr_reg;
                pend_next = pend_reg;
                if (tmr_reg != 5'd0) begin
                    tmr_next = tmr_reg - 5'd1;
                    if (event_req[gi]) begin
                        pend_next = 1'b1;
                    end
                end else if (pend_reg || event_req[gi]) begin
                    tmr_next  = STRETCH_LOAD;
                    pend_next = 1'b0;
                end
            end

            always_ff @(posedge sys_clk_i or posedge rst_i) begin
                if (rst_i) begin
                    tmr_reg  <= 5'd0;
                    pend_reg <= 1'b0;
                    evt_reg  <= 1'b0;
                end else begin
                    tmr_reg  <= tmr_next;
                    pend_reg <= pend_next;
                    evt_reg  <= (tmr_next >= 5'd2);
                end
            end

            assign event_o[gi] = evt_reg;
        end
    endgenerate

endmodule
